ex_branch_pipe: RTL and testbench

Parametrised, registered branch execution unit with a result queue. It sits between the branch reservation station and the ROB. It resolves conditional branches plus `JAL`/`JALR`, computes the link value, and flags mispredictions against the predicted target. Results are buffered in a `DEPTH`-entry show-ahead FIFO behind a valid/ready handshake, and a flush input squashes all in-flight work.

---
 rtl/ex_branch_pipe.sv | 135 +++++++++++++
 tb/tb_ex_branch_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_branch_pipe.sv
// ex_branch_pipe: resolves branches/jumps and queues results in a show-ahead FIFO
`ifndef tagWidth
`define tagWidth 6
`endif
`ifndef newopWidth
`define newopWidth 4
`endif
`ifndef tagFree
`define tagFree {`tagWidth{1'b1}}
`endif
`ifndef BEQ
`define BEQ  4'd1
`define BNE  4'd2
`define BLT  4'd3
`define BGE  4'd4
`define BLTU 4'd5
`define BGEU 4'd6
`define JAL  4'd7
`define JALR 4'd8
`endif

module ex_branch_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = `tagWidth,
   parameter int OP_W   = `newopWidth,
   parameter int DEPTH  = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_offset,
   input  logic [ADDR_W-1:0] in_pred,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_taken,
   output logic [ADDR_W-1:0] out_target,
   output logic [DATA_W-1:0] out_link,
   output logic              out_mispredict,
   output logic [TAG_W-1:0]  out_tag
);
   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc4, br_tgt, jalr_tgt, tgt;
   logic [DATA_W-1:0] link;
   logic              taken, is_link, eq, lt, ltu;
   logic              push, pop;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;

   logic              taken_q  [DEPTH];
   logic [ADDR_W-1:0] target_q [DEPTH];
   logic [DATA_W-1:0] link_q   [DEPTH];
   logic              misp_q   [DEPTH];
   logic [TAG_W-1:0]  tag_q    [DEPTH];

   // Operand sums are truncated to the PC width so targets wrap modulo 2^ADDR_W
   assign pc4      = in_pc + ADDR_W'(4);
   assign br_tgt   = in_pc + in_offset[ADDR_W-1:0];
   assign jalr_tgt = (in_src1[ADDR_W-1:0] + in_offset[ADDR_W-1:0]) & ~ADDR_W'(1);
   assign eq       = in_src1 == in_src2;
   assign lt       = $signed(in_src1) < $signed(in_src2);
   assign ltu      = in_src1 < in_src2;

   // Decode direction and next PC; unknown opcodes fall through as not-taken
   always_comb begin
      taken   = 1'b0;
      is_link = 1'b0;
      case (in_op)
         OP_W'(`BEQ):  taken = eq;
         OP_W'(`BNE):  taken = !eq;
         OP_W'(`BLT):  taken = lt;
         OP_W'(`BGE):  taken = !lt;
         OP_W'(`BLTU): taken = ltu;
         OP_W'(`BGEU): taken = !ltu;
         OP_W'(`JAL), OP_W'(`JALR): begin
            taken   = 1'b1;
            is_link = 1'b1;
         end
         default: ;
      endcase
      tgt  = !taken ? pc4 : (in_op == OP_W'(`JALR)) ? jalr_tgt : br_tgt;
      link = is_link ? DATA_W'(pc4) : '0;
   end

   assign in_ready  = count_q != (PW+1)'(DEPTH);
   assign out_valid = count_q != '0;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // Flush wins over any same-cycle push or pop
   always_comb begin
      wr_ptr_d = flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Result storage; contents only matter while counted as occupied
   always_ff @(posedge clk) begin
      if (push) begin
         taken_q[wr_ptr_q]  <= taken;
         target_q[wr_ptr_q] <= tgt;
         link_q[wr_ptr_q]   <= link;
         misp_q[wr_ptr_q]   <= tgt != in_pred;
         tag_q[wr_ptr_q]    <= in_tag;
      end
   end

   assign out_taken      = out_valid & taken_q[rd_ptr_q];
   assign out_target     = out_valid ? target_q[rd_ptr_q] : '0;
   assign out_link       = out_valid ? link_q[rd_ptr_q] : '0;
   assign out_mispredict = out_valid & misp_q[rd_ptr_q];
   assign out_tag        = out_valid ? tag_q[rd_ptr_q] : TAG_W'(`tagFree);

endmodule

// File: tb/tb_ex_branch_pipe.sv
// tb_ex_branch_pipe: scoreboard bench for the branch execution unit
`ifndef tagWidth
`define tagWidth 6
`endif
`ifndef newopWidth
`define newopWidth 4
`endif
`ifndef tagFree
`define tagFree {`tagWidth{1'b1}}
`endif
`ifndef BEQ
`define BEQ  4'd1
`define BNE  4'd2
`define BLT  4'd3
`define BGE  4'd4
`define BLTU 4'd5
`define BGEU 4'd6
`define JAL  4'd7
`define JALR 4'd8
`endif

module tb_ex_branch_pipe;
   logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic        in_ready, out_valid, out_taken, out_mispredict;
   logic [3:0]  in_op = 0;
   logic [31:0] in_src1 = 0, in_src2 = 0, in_pc = 0, in_offset = 0, in_pred = 0;
   logic [5:0]  in_tag = 0, out_tag;
   logic [31:0] out_target, out_link;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        misp;
      logic [5:0]  tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;
   localparam logic [5:0] TAG_FREE = `tagFree;

   ex_branch_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc),
      .in_offset(in_offset), .in_pred(in_pred), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_target(out_target), .out_link(out_link),
      .out_mispredict(out_mispredict), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] s1, s2, pc, off, pred,
                        input logic [5:0] tag);
      in_op = op; in_src1 = s1; in_src2 = s2; in_pc = pc;
      in_offset = off; in_pred = pred; in_tag = tag; in_valid = 1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] s1, s2, pc, off, pred,
                        input logic [5:0] tag, input logic e_tk, input logic [31:0] e_tgt,
                        input logic [31:0] e_lnk, input logic e_mp);
      int n = 0;
      drive(op, s1, s2, pc, off, pred, tag);
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: tag %0d never accepted", tag);
      end else
         q.push_back(exp_t'{e_tk, e_tgt, e_lnk, e_mp, tag});
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_done", {31'd0, q.size() == 0 && !out_valid}, 32'd1);
   endtask

   // Monitor: compare the head against the scoreboard whenever it is consumed
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && !flush && out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: tag %0h target %0h with empty scoreboard",
                        out_tag, out_target);
            end else begin
               e = q.pop_front();
               chk("tag", {26'd0, out_tag}, {26'd0, e.tag});
               chk("taken", {31'd0, out_taken}, {31'd0, e.taken});
               chk("target", out_target, e.target);
               chk("link", out_link, e.link);
               chk("mispredict", {31'd0, out_mispredict}, {31'd0, e.misp});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_tag", {26'd0, out_tag}, {26'd0, TAG_FREE});
      chk("rst_target", out_target, 32'd0);
      chk("rst_link", out_link, 32'd0);
      chk("rst_taken", {31'd0, out_taken | out_mispredict}, 32'd0);

      issue(`BEQ, 5, 5, 32'h100, 32'h20, 32'h104, 3, 1, 32'h120, 0, 1);
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      wait_empty();

      issue(`BLT,  32'hFFFFFFFF, 1, 32'h200, 32'h40, 32'h240, 4, 1, 32'h240, 0, 0);
      issue(`BLTU, 32'hFFFFFFFF, 1, 32'h200, 32'h40, 32'h240, 5, 0, 32'h204, 0, 1);
      issue(`JALR, 32'h203, 0, 32'h400, 32'h10, 32'h212, 6, 1, 32'h212, 32'h404, 0);
      issue(`JAL,  0, 0, 32'h500, 32'hFFFFFFF0, 32'h504, 7, 1, 32'h4F0, 32'h504, 1);
      issue(`BNE,  1, 2, 32'hFFFFFFFC, 8, 4, 8, 1, 32'h4, 0, 0);
      issue(`BNE,  3, 3, 32'hFFFFFFFC, 8, 4, 9, 0, 32'h0, 0, 1);
      issue(`BGE,  1, 32'hFFFFFFFF, 32'h600, 32'h100, 32'h700, 10, 1, 32'h700, 0, 0);
      issue(`BGEU, 1, 32'hFFFFFFFF, 32'h600, 32'h100, 32'h700, 11, 0, 32'h604, 0, 1);
      issue(4'hF,  0, 0, 32'h800, 32'h40, 32'h804, 12, 0, 32'h804, 0, 0);
      wait_empty();

      out_ready = 0;
      for (int i = 0; i < 4; i++)
         issue(`BEQ, i, i, 32'h1000, 32'h8, 32'h1008, 6'(i), 1, 32'h1008, 0, 0);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      drive(`BEQ, 0, 0, 32'h2000, 0, 0, 6'd40);
      @(posedge clk); #1;
      in_valid = 0;
      chk("full_refuse", {31'd0, in_ready}, 32'd0);
      out_ready = 1;
      @(posedge clk); #1;
      chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
      wait_empty();

      out_ready = 0;
      for (int i = 0; i < 3; i++)
         issue(`BNE, 1, 0, 32'h3000, 32'h10, 0, 6'(20 + i), 1, 32'h3010, 0, 1);
      drive(`JAL, 0, 0, 32'h3100, 32'h20, 0, 6'd23);
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      in_valid = 0;
      q.delete();
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_out_tag", {26'd0, out_tag}, {26'd0, TAG_FREE});
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

      drive(`JAL, 0, 0, 32'h3200, 32'h20, 0, 6'd24);
      flush = 1;
      repeat (2) @(posedge clk);
      #1 flush = 0;
      in_valid = 0;
      chk("flush2_out_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1;
      repeat (5) @(posedge clk);
      #1;
      issue(`JAL, 0, 0, 32'h3300, 32'h8, 32'h3308, 25, 1, 32'h3308, 32'h3304, 0);
      wait_empty();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
